// File: rtl/mux_key_table.sv
// Registered, runtime-programmable key/data lookup table with a valid/ready request and result stage.
// Define MUX_KEY_TABLE_STATS_EN to add saturating hit/miss counters (hit_cnt, miss_cnt).
module mux_key_table #(
    parameter int  NR_KEY   = 4,
    parameter int  KEY_LEN  = 2,
    parameter int  DATA_LEN = 2,
    localparam int IDX_LEN  = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_vld,
    input  logic                def_en,
    input  logic [DATA_LEN-1:0] def_data,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_LEN-1:0]  in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_hit,
    output logic [IDX_LEN-1:0]  out_idx
`ifdef MUX_KEY_TABLE_STATS_EN
    ,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
`endif
);

    localparam int unsigned NR_U = NR_KEY;

    logic                vld_q  [NR_KEY];
    logic                vld_d  [NR_KEY];
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [KEY_LEN-1:0]  key_d  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] data_d [NR_KEY];
    logic [DATA_LEN-1:0] def_q, def_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] out_data_q, out_data_d;
    logic                out_hit_q, out_hit_d;
    logic [IDX_LEN-1:0]  out_idx_q, out_idx_d;

    logic                accept;
    logic                lk_hit;
    logic [IDX_LEN-1:0]  lk_idx;
    logic [DATA_LEN-1:0] lk_data;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Table/default updates; the loop only visits real entries, so an out-of-range wr_idx matches nothing.
    always_comb begin
        vld_d  = vld_q;
        key_d  = key_q;
        data_d = data_q;
        def_d  = def_q;
        if (clr) begin
            for (int unsigned i = 0; i < NR_U; i++) begin
                vld_d[i] = 1'b0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NR_U; i++) begin
                if (wr_idx == i[IDX_LEN-1:0]) begin
                    vld_d[i]  = wr_vld;
                    key_d[i]  = wr_key;
                    data_d[i] = wr_data;
                end
            end
        end
        if (def_en) begin
            def_d = def_data;
        end
    end

    // Lookup against the pre-edge table; the first hit in ascending order wins outright.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        lk_data = def_q;
        for (int unsigned i = 0; i < NR_U; i++) begin
            if (!lk_hit && vld_q[i] && (key_q[i] == in_key)) begin
                lk_hit  = 1'b1;
                lk_idx  = i[IDX_LEN-1:0];
                lk_data = data_q[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lk_data;
            out_hit_d   = lk_hit;
            out_idx_d   = lk_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NR_U; i++) begin
                vld_q[i]  <= 1'b0;
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
            def_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            vld_q       <= vld_d;
            key_q       <= key_d;
            data_q      <= data_d;
            def_q       <= def_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_hit   = out_hit_q;
    assign out_idx   = out_idx_q;

`ifdef MUX_KEY_TABLE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (accept) begin
            if (lk_hit && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end
            if (!lk_hit && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/mux_key_table.md
# mux_key_table

Programmable, registered successor to the combinational key-lookup mux: a table of NR_KEY runtime-writable key/data entries, plus a programmable default value. Lookup requests arrive through a valid/ready handshake. Each accepted key yields, one cycle later, the matching data (lowest-index hit), the hit flag and the matching index, held until the consumer accepts it. The block sits between a decode/dispatch front end and the datapath, replacing fixed constant LUTs wherever the mapping must be reconfigured without resynthesis.

## Interface
- NR_KEY, 4, number of table entries (≥1)
- KEY_LEN, 2, key width in bits
- DATA_LEN, 2, data width in bits
- IDX_LEN, $clog2(NR_KEY) (min 1), index width, derived; do not override
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one table entry this cycle
- wr_idx  in  IDX_LEN  entry to write; values ≥ NR_KEY are ignored
- wr_key  in  KEY_LEN  key stored on write
- wr_data  in  DATA_LEN  data stored on write
- wr_vld  in  1  entry-valid bit stored on write (0 = delete entry)
- def_en  in  1  load default register this cycle
- def_data  in  DATA_LEN  new default value
- clr  in  1  invalidate all entries (default register kept)
- in_valid  in  1  lookup request valid
- in_ready  out  1  block can accept a lookup
- in_key  in  KEY_LEN  key to look up
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_LEN  matched data, or default on miss
- out_hit  out  1  1 = some valid entry matched
- out_idx  out  IDX_LEN  index of matching entry; 0 on miss

## Operation
- Table: NR_KEY entries, each holding {vld, key, data}. A match requires vld=1 and key==in_key.
- Priority: when several valid entries match, the lowest index wins, and out_data is that entry's data only. Data from different entries is never OR'd together.
- Miss: out_data=default register, out_hit=0, out_idx=0.
- Accept: a request is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (single output stage, full throughput).
- Result register: loaded on accept. When out_ready=1 and no accept occurs, out_valid falls to 0. While out_valid=1 and out_ready=0, all out_* outputs are held stable.
- Write/clear precedence: clr wins over wr_en in the same cycle, so all entries end up invalid. A wr_en to a valid index updates only that entry.
- Write-read ordering: a lookup in the same cycle as wr_en/clr/def_en sees the table and default as they were before that edge. The update is visible from the next accepted lookup.
- Results already held in the output register are never altered by later writes.

## Timing
- Reset (rst_n=0, asynchronous): all vld=0, keys and data 0, default 0, out_valid=0, out_data=0, out_hit=0, out_idx=0. in_ready=1 as soon as reset is released.
- Latency: 1 cycle from accept edge to out_valid=1.
- Throughput: 1 lookup/cycle while out_ready=1.
- in_ready is combinational from out_ready. No other combinational path runs from inputs to outputs.
- Reset asserted mid-transfer drops the pending result; the consumer must not rely on it.

## Configuration
- MUX_KEY_TABLE_STATS_EN defined: adds outputs hit_cnt and miss_cnt (each 16 bits, out).
  - Each counter increments on every accepted lookup that hits or misses, respectively.
  - Each counter saturates at 16'hFFFF.
  - Both reset to 0 on rst_n and on clr.
- Undefined: the counters and ports are absent, and behaviour is otherwise identical.

## Test plan
- Reset then lookup key 2'b01 with an empty table -> next cycle out_valid=1, out_hit=0, out_data=2'b00, out_idx=0.
- Write entries {0:key 00→11, 1:key 01→10, 2:key 10→01, 3:key 11→00}, then stream keys 00,01,10,11 with out_ready=1 -> outputs 11,10,01,00 on consecutive cycles, idx 0..3, in_ready constantly 1.
- Write entry 1 and entry 3 both with key 01 (data 10 and 01) -> lookup 01 returns data 10, idx 1, hit=1.
- def_data=2'b10 and a lookup of absent key 11 in the same cycle -> result 00 (old default). The same lookup repeated next -> 10.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen. Release -> the queued key is accepted on the release cycle and its result appears one cycle later.
- With MUX_KEY_TABLE_STATS_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2. Asserting clr -> both 0 and all entries invalid.
